pcs_rx_seq_ctrl: RTL
====================

// Module: pcs_rx_seq_ctrl
// PURPOSE
//  Receive sequencing controller behind the 64b/66b decoder and the x(l)gmii decode interface.
//  - Classifies every decoded block as C/S/D/T/E and runs the clause 49 receive state machine.
//  - Checks block ordering with one block of lookahead.
//  - Forwards legal blocks unchanged; replaces illegal blocks with EBLOCK_R.
//  - Sends LBLOCK_R (local fault) while block lock is down. Counts error blocks.
// PARAMETERS
//  IS_40G        1   1: 40G (start lane 0 only); 0: 10G (start lane 0 or 4)
//  LANE0_CNT_N   IS_40G?1:2   width of start_v_i (derived, do not override)
//  XGMII_DATA_W  64  x(l)gmii data width
//  XGMII_CTRL_W  8   x(l)gmii control width (XGMII_DATA_W/8)
//  ERR_CNT_W     16  error block counter width
// PORTS
//  clk           in   1             clock
//  nreset        in   1             asynchronous reset, active low
//  valid_i       in   1             block present this cycle (low on gearbox stall)
//  block_lock_i  in   1             block lock from sync-header lock FSM
//  head_err_i    in   1             sync header is neither 2'b01 nor 2'b10
//  ctrl_v_i      in   1             control block (header 2'b10)
//  start_v_i     in   LANE0_CNT_N   start detected per lane-0 position
//  term_v_i      in   1             terminate block
//  err_v_i       in   1             invalid block type / control code from decoder
//  rxd_i         in   XGMII_DATA_W  decoded x(l)gmii data
//  rxc_i         in   XGMII_CTRL_W  decoded x(l)gmii control
//  cnt_clr_i     in   1             synchronous clear of err_cnt_o
//  valid_o       out  1             output block valid
//  xgmii_rxd_o   out  XGMII_DATA_W  sequenced x(l)gmii data
//  xgmii_rxc_o   out  XGMII_CTRL_W  sequenced x(l)gmii control
//  state_o       out  3             INIT=0, C=1, D=2, T=3, E=4
//  err_cnt_o     out  ERR_CNT_W     saturating count of EBLOCK_R blocks emitted
// BEHAVIOUR
//  Classification of the incoming block, in priority order:
//   head_err_i|err_v_i -> E; ~ctrl_v_i -> D; |start_v_i -> S; term_v_i -> T; else -> C.
//  Pipeline:
//   - One holding stage stores class, rxd and rxc of block n.
//   - Block n is decided when block n+1 is accepted (valid_i=1), using n+1's class as "next".
//   - Decided block n is registered on xgmii_*_o with valid_o=1 in the cycle after n+1 is accepted.
//   - valid_i=0: stage, state and outputs hold; valid_o=0.
//   - First valid block after lock is gained only fills the stage; valid_o=0 for it.
//  FSM (transition evaluated for held block n):
//   INIT: C->C, S->D, else->E
//   C:    C->C, S->D, else->E
//   D:    D->D; T & next in {C,S}->T; else->E
//   T:    C->C, S->D, else->E
//   E:    C->C, D->D; T & next in {C,S}->T; else->E
//  Output per decision:
//   - Next state E: EBLOCK_R (rxd all 8'hFE, rxc 8'hFF).
//   - Otherwise: held rxd/rxc, unchanged.
//  Lock loss:
//   - block_lock_i=0 flushes the stage (held block dropped) and forces INIT, including mid-frame.
//   - Each valid_i cycle then emits LBLOCK_R next cycle with valid_o=1:
//     rxd 64'h0100_009C_0100_009C, rxc 8'h11.
//  err_cnt_o:
//   - +1 per emitted EBLOCK_R; saturates at all-ones.
//   - cnt_clr_i wins over a same-cycle increment (result 0).
//   - LBLOCK_R blocks are not counted.
//  Reset values: state INIT, stage empty, valid_o 0, xgmii_rxd_o = LBLOCK_R data,
//   xgmii_rxc_o 8'h11, err_cnt_o 0.
// TESTING
//  1 Lock up; blocks C,C,S,D,D,T,C -> same words out 2 cycles after each, no EBLOCK_R, err_cnt_o=0.
//  2 D,D,T then D (next not C/S) -> the T block is output as FE..FE/FF, state E, err_cnt_o=1.
//  3 In C, feed D -> EBLOCK_R; then C -> C passthrough, state C.
//  4 head_err_i=1 on a D inside a frame -> EBLOCK_R for that block; err_v_i on a C block -> EBLOCK_R.
//  5 Drop block_lock_i mid-frame -> LBLOCK_R 64'h0100_009C_0100_009C/8'h11 per valid cycle, state 0;
//    relock -> first block only fills the stage.
//  6 valid_i toggling 1/0 during a frame -> outputs and state hold on stalls.
//    err_cnt_o saturates at 16'hFFFF; cnt_clr_i with a same-cycle error -> 0.

Source files
------------

// File: rtl/pcs_rx_seq_ctrl.sv
// Receive sequencing controller: classifies decoded 64b/66b blocks, runs the
// receive state machine with one block of lookahead, and substitutes EBLOCK_R / LBLOCK_R.
module pcs_rx_seq_ctrl #(
   parameter int IS_40G       = 1,
   parameter int LANE0_CNT_N  = (IS_40G != 0) ? 1 : 2,
   parameter int XGMII_DATA_W = 64,
   parameter int XGMII_CTRL_W = 8,
   parameter int ERR_CNT_W    = 16
)(
   input  logic                    clk,
   input  logic                    nreset,
   input  logic                    valid_i,
   input  logic                    block_lock_i,
   input  logic                    head_err_i,
   input  logic                    ctrl_v_i,
   input  logic [LANE0_CNT_N-1:0]  start_v_i,
   input  logic                    term_v_i,
   input  logic                    err_v_i,
   input  logic [XGMII_DATA_W-1:0] rxd_i,
   input  logic [XGMII_CTRL_W-1:0] rxc_i,
   input  logic                    cnt_clr_i,
   output logic                    valid_o,
   output logic [XGMII_DATA_W-1:0] xgmii_rxd_o,
   output logic [XGMII_CTRL_W-1:0] xgmii_rxc_o,
   output logic [2:0]              state_o,
   output logic [ERR_CNT_W-1:0]    err_cnt_o
);

   typedef enum logic [2:0] {ST_INIT = 3'd0, ST_C = 3'd1, ST_D = 3'd2, ST_T = 3'd3, ST_E = 3'd4} state_t;
   typedef enum logic [2:0] {CL_C, CL_S, CL_D, CL_T, CL_E} cls_t;

   localparam logic [XGMII_DATA_W-1:0] EBLK_D = {(XGMII_DATA_W/8){8'hFE}};
   localparam logic [XGMII_CTRL_W-1:0] EBLK_C = {XGMII_CTRL_W{1'b1}};
   localparam logic [XGMII_DATA_W-1:0] LBLK_D = {(XGMII_DATA_W/32){32'h0100_009C}};
   localparam logic [XGMII_CTRL_W-1:0] LBLK_C = {(XGMII_CTRL_W/4){4'h1}};

   state_t                  state, state_nxt, tgt;
   cls_t                    cls, hold_cls;
   logic                    hold_vld, decide, next_cs, err_inc;
   logic [XGMII_DATA_W-1:0] hold_rxd, rxd_nxt;
   logic [XGMII_CTRL_W-1:0] hold_rxc, rxc_nxt;
   logic                    vld_nxt;

   always_comb begin
      cls = CL_C;
      if (head_err_i | err_v_i)  cls = CL_E;
      else if (!ctrl_v_i)        cls = CL_D;
      else if (|start_v_i)       cls = CL_S;
      else if (term_v_i)         cls = CL_T;
   end

   // Held block n is decided only when block n+1 arrives, so its class is the lookahead.
   assign decide  = valid_i & block_lock_i & hold_vld;
   assign next_cs = (cls == CL_C) || (cls == CL_S);

   always_comb begin
      tgt = ST_E;
      unique case (state)
         ST_D: begin
            if (hold_cls == CL_D)                 tgt = ST_D;
            else if (hold_cls == CL_T && next_cs) tgt = ST_T;
         end
         ST_E: begin
            if (hold_cls == CL_C)                 tgt = ST_C;
            else if (hold_cls == CL_D)            tgt = ST_D;
            else if (hold_cls == CL_T && next_cs) tgt = ST_T;
         end
         default: begin
            if (hold_cls == CL_C)                 tgt = ST_C;
            else if (hold_cls == CL_S)            tgt = ST_D;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (!block_lock_i) state_nxt = ST_INIT;
      else if (decide)   state_nxt = tgt;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= ST_INIT;
      else         state <= state_nxt;
   end

   always_comb begin
      vld_nxt = 1'b0;
      rxd_nxt = xgmii_rxd_o;
      rxc_nxt = xgmii_rxc_o;
      err_inc = 1'b0;
      if (!block_lock_i) begin
         if (valid_i) begin
            vld_nxt = 1'b1;
            rxd_nxt = LBLK_D;
            rxc_nxt = LBLK_C;
         end
      end else if (decide) begin
         vld_nxt = 1'b1;
         if (tgt == ST_E) begin
            rxd_nxt = EBLK_D;
            rxc_nxt = EBLK_C;
            err_inc = 1'b1;
         end else begin
            rxd_nxt = hold_rxd;
            rxc_nxt = hold_rxc;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         hold_vld <= 1'b0;
         hold_cls <= CL_C;
         hold_rxd <= '0;
         hold_rxc <= '0;
      end else if (!block_lock_i) begin
         hold_vld <= 1'b0;
      end else if (valid_i) begin
         hold_vld <= 1'b1;
         hold_cls <= cls;
         hold_rxd <= rxd_i;
         hold_rxc <= rxc_i;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_o     <= 1'b0;
         xgmii_rxd_o <= LBLK_D;
         xgmii_rxc_o <= LBLK_C;
      end else begin
         valid_o     <= vld_nxt;
         xgmii_rxd_o <= rxd_nxt;
         xgmii_rxc_o <= rxc_nxt;
      end
   end

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                         err_cnt_o <= '0;
      else if (cnt_clr_i)                  err_cnt_o <= '0;
      else if (err_inc && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
   end

   assign state_o = state;

endmodule
